// File: rtl/ss_pkg.sv
// rtl/ss_pkg.sv - shared constants for the seven-segment multiplexed display driver
package ss_pkg;

  // Value driven on SevenSegment when no digit is lit (active low, all off)
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Digit index register width; covers the full 1..8 digit range
  localparam int IDX_W = 3;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex values 0..F
  localparam logic [6:0] HEX_SEGS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-high segment decoder
module hex7seg
  import ss_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup of the full hex glyph set
  always_comb begin
    seg_o = HEX_SEGS[hex_i];
  end

endmodule

// File: rtl/ss_mux_driver.sv
// rtl/ss_mux_driver.sv - time-multiplexed seven-segment driver with PWM brightness
module ss_mux_driver
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_W     = 14,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   Blank,
  input  logic                    LeadZeroSup,
  input  logic [BRIGHT_W-1:0]     Brightness,
  output logic [NUM_DIGITS-1:0]   SegmentDrivers,
  output logic [7:0]              SevenSegment,
  output logic                    FrameStart
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [SLOT_W-1:0] slot_q;
  logic [IDX_W-1:0]  idx_q;
  logic              slot_wrap;
  logic              frame_bnd;

  // Snapshot of the display content for the current frame
  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic [NUM_DIGITS-1:0]   snap_blank_q;
  logic                    snap_lzs_q;
  logic                    cap_pend_q;

  // View used for decoding: the live inputs on the capture clock right
  // after reset so the first lit slot already shows fresh content
  logic [4*NUM_DIGITS-1:0] eff_digits;
  logic [NUM_DIGITS-1:0]   eff_dp;
  logic [NUM_DIGITS-1:0]   eff_blank;
  logic                    eff_lzs;

  // Current-digit decode
  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_supp;
  logic [6:0]            cur_seg;
  logic                  bright_ok;
  logic                  digit_on;
  logic [NUM_DIGITS-1:0] drv_d;
  logic [7:0]            seg_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] drv_q;
  logic [7:0]            seg_q;
  logic                  fs_q;

  assign slot_wrap = &slot_q;
  assign frame_bnd = slot_wrap && (idx_q == LAST_IDX);

  // Free-running slot counter; digit index steps on every slot wrap
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      slot_q <= '0;
      idx_q  <= '0;
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
      if (slot_wrap) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Capture display content on the first clock after reset and at each frame boundary
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      snap_lzs_q    <= 1'b0;
      cap_pend_q    <= 1'b1;
    end else begin
      if (cap_pend_q || frame_bnd) begin
        snap_digits_q <= Digits;
        snap_dp_q     <= DP;
        snap_blank_q  <= Blank;
        snap_lzs_q    <= LeadZeroSup;
      end
      cap_pend_q <= 1'b0;
    end
  end

  // Select live inputs only on the pending-capture clock, else the frame snapshot
  always_comb begin
    eff_digits = cap_pend_q ? Digits      : snap_digits_q;
    eff_dp     = cap_pend_q ? DP          : snap_dp_q;
    eff_blank  = cap_pend_q ? Blank       : snap_blank_q;
    eff_lzs    = cap_pend_q ? LeadZeroSup : snap_lzs_q;
  end

  // Pick the current digit's fields and evaluate leading-zero suppression from the top down
  always_comb begin
    logic tail_zero;
    cur_hex   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    tail_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      tail_zero = tail_zero && (eff_digits[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        cur_hex   = eff_digits[4*i +: 4];
        cur_dp    = eff_dp[i];
        cur_blank = eff_blank[i];
        cur_supp  = eff_lzs && (i > 0) && tail_zero;
      end
    end
  end

  hex7seg u_hex7seg (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  assign bright_ok = (slot_q[SLOT_W-1 -: BRIGHT_W] <= Brightness);
  assign digit_on  = Enable && !cur_blank && !cur_supp && bright_ok;

  // Next driver/segment values: at most the current digit pulled low
  always_comb begin
    drv_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_on && (idx_q == IDX_W'(i))) begin
        drv_d[i] = 1'b0;
      end
    end
    seg_d = digit_on ? {~cur_dp, ~cur_seg} : SEG_OFF;
  end

  // Output registers; reset forces the display dark immediately
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      drv_q <= '1;
      seg_q <= SEG_OFF;
      fs_q  <= 1'b0;
    end else begin
      drv_q <= drv_d;
      seg_q <= seg_d;
      fs_q  <= frame_bnd;
    end
  end

  assign SegmentDrivers = drv_q;
  assign SevenSegment   = seg_q;
  assign FrameStart     = fs_q;

endmodule

// File: tb/tb_ss_mux_driver.sv
// tb/tb_ss_mux_driver.sv - scoreboard bench for the multiplexed seven-segment driver
module tb_ss_mux_driver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic [15:0] Digits = 16'h0;
  logic [3:0]  DP = 4'h0;
  logic [3:0]  Blank = 4'h0;
  logic        LeadZeroSup = 1'b0;
  logic [1:0]  Brightness = 2'd0;
  logic [3:0]  SegmentDrivers;
  logic [7:0]  SevenSegment;
  logic        FrameStart;

  ss_mux_driver #(
    .NUM_DIGITS (4),
    .SLOT_W     (4),
    .BRIGHT_W   (2)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Enable         (Enable),
    .Digits         (Digits),
    .DP             (DP),
    .Blank          (Blank),
    .LeadZeroSup    (LeadZeroSup),
    .Brightness     (Brightness),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment),
    .FrameStart     (FrameStart)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] drv;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_slot;
  int          m_idx;
  bit          m_pend;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  bit          m_lzs;
  int          tick_no = 0;
  int          last_fs = -1;
  int          low0 = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_slot  = 0;
    m_idx   = 0;
    m_pend  = 1;
    m_dig   = '0;
    m_dp    = '0;
    m_blank = '0;
    m_lzs   = 0;
    last_fs = -1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_drivers"}, SegmentDrivers, 4'hF);
    chk({tag, "_seven_seg"}, SevenSegment, 8'hFF);
    chk({tag, "_frame_start"}, FrameStart, 1'b0);
  endtask

  task automatic tick();
    exp_t        e;
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
    bit          lz;
    bit          supp;
    bit          on;
    int          h;
    d  = m_pend ? Digits      : m_dig;
    dp = m_pend ? DP          : m_dp;
    bl = m_pend ? Blank       : m_blank;
    lz = m_pend ? LeadZeroSup : m_lzs;
    h    = int'((d >> (4 * m_idx)) & 16'hF);
    supp = lz && (m_idx > 0) && ((d >> (4 * m_idx)) == 16'h0);
    on   = Enable && !bl[m_idx] && !supp && ((m_slot / 4) <= int'(Brightness));
    e.drv = on ? ~(4'b0001 << m_idx) : 4'hF;
    e.seg = on ? {~dp[m_idx], ~glyph[h]} : 8'hFF;
    e.fs  = (m_slot == 15) && (m_idx == 3);
    sb.push_back(e);
    if (m_pend || e.fs) begin
      m_dig   = Digits;
      m_dp    = DP;
      m_blank = Blank;
      m_lzs   = LeadZeroSup;
    end
    m_pend = 0;
    if (m_slot == 15) m_idx = (m_idx + 1) % 4;
    m_slot = (m_slot + 1) % 16;
    @(posedge Clk);
    #1;
    tick_no++;
    e = sb.pop_front();
    chk("drivers", SegmentDrivers, e.drv);
    chk("seven_seg", SevenSegment, e.seg);
    chk("frame_start", FrameStart, e.fs);
    chk("single_driver_low", ($countones(~SegmentDrivers) <= 1), 1'b1);
    if (SegmentDrivers[0] === 1'b0) low0++;
    if (FrameStart === 1'b1) begin
      if (last_fs >= 0) chk("frame_period", tick_no - last_fs, 64);
      last_fs = tick_no;
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    reset_checks("reset_hold");

    // Basic scan of 12AF at full brightness
    Digits = 16'h12AF;
    Brightness = 2'd3;
    Enable = 1'b1;
    Reset = 1'b1;
    tick();
    chk("first_digit_driver", SegmentDrivers, 4'hE);
    chk("first_digit_glyph_F", SevenSegment, 8'h8E);
    repeat (140) tick();

    // Leading-zero suppression
    LeadZeroSup = 1'b1;
    Digits = 16'h0050;
    repeat (140) tick();
    Digits = 16'h0000;
    repeat (140) tick();

    // PWM brightness: digit 0 lit count over one full frame
    LeadZeroSup = 1'b0;
    Digits = 16'h12AF;
    repeat (70) tick();
    Brightness = 2'd0;
    low0 = 0;
    repeat (64) tick();
    chk("bright0_low_count", low0, 4);
    Brightness = 2'd2;
    low0 = 0;
    repeat (64) tick();
    chk("bright2_low_count", low0, 12);

    // Decimal points, blanking, and display disable
    Brightness = 2'd3;
    DP = 4'b0101;
    Blank = 4'b0010;
    repeat (140) tick();
    Enable = 1'b0;
    repeat (40) tick();
    Enable = 1'b1;
    DP = 4'b0000;
    Blank = 4'b0000;

    // Mid-frame content change only appears after the next frame boundary
    Digits = 16'h1111;
    repeat (140) tick();
    while (m_idx != 1) tick();
    repeat (3) tick();
    Digits = 16'h2222;
    repeat (140) tick();

    // Asynchronous reset during digit 2
    while (!(m_idx == 2 && m_slot == 6)) tick();
    #2;
    Reset = 1'b0;
    #1;
    reset_checks("async_reset");
    model_reset();
    @(posedge Clk);
    #1;
    reset_checks("reset_held_edge");
    Reset = 1'b1;
    Digits = 16'h3456;
    tick();
    chk("restart_digit0_driver", SegmentDrivers, 4'hE);
    repeat (140) tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ss_mux_driver.md
SS_MUX_DRIVER -- requirements
Module: ss_mux_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter SLOT_W, default 14, log2 of clocks per digit slot.
REQ-003 SHALL have parameter BRIGHT_W, default 4, brightness width (BRIGHT_W <= SLOT_W).
REQ-004 SHALL have port Clk, input, 1, the single clock.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port Enable, input, 1, display on when high.
REQ-007 SHALL have port Digits, input, 4*NUM_DIGITS, hex value per digit (digit i = bits 4i+3:4i).
REQ-008 SHALL have port DP, input, NUM_DIGITS, decimal point per digit, active high.
REQ-009 SHALL have port Blank, input, NUM_DIGITS, forced-off mask per digit, active high.
REQ-010 SHALL have port LeadZeroSup, input, 1, leading-zero suppression enable.
REQ-011 SHALL have port Brightness, input, BRIGHT_W, PWM duty code.
REQ-012 SHALL have port SegmentDrivers, output, NUM_DIGITS, digit drivers, active low.
REQ-013 SHALL have port SevenSegment, output, 8, bit 7 = DP, bits 6:0 = segments g..a, active low.
REQ-014 SHALL have port FrameStart, output, 1, one-clock pulse at each frame boundary.

Function
REQ-015 SHALL count a free-running SLOT_W-bit slot counter; when it wraps (all ones -> 0), the digit index SHALL advance 0,1,...,NUM_DIGITS-1, then wrap to 0.
REQ-016 SHALL define the frame boundary as the clock where the slot counter wraps while the index is NUM_DIGITS-1; on it, FrameStart SHALL be high for exactly that cycle.
REQ-017 SHALL capture Digits, DP, Blank, LeadZeroSup into snapshot registers on each frame boundary and on the first clock after Reset deasserts; between captures, input changes SHALL have no effect on outputs.
REQ-018 SHALL decode the snapshot digit at the current index through the hex decoder (0-F, full hex glyphs).
REQ-019 SHALL treat digit i as suppressed when snapshot LeadZeroSup=1, i>0, and snapshot digits i..NUM_DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-020 SHALL drive the current digit low on SegmentDrivers only when Enable=1, it is neither Blank nor suppressed, and the top BRIGHT_W bits of the slot counter are <= Brightness; otherwise all drivers high.
REQ-021 SHALL drive SevenSegment = {~DP, ~segments} of the current digit when its driver is low, else 8'hFF.
REQ-022 SHALL register SegmentDrivers and SevenSegment; outputs SHALL reflect index/counter state with exactly 1 clock of latency, and at most one driver low at any time.
REQ-023 SHALL keep the counter and index running while Enable=0.

Reset
REQ-024 While Reset is low: slot counter 0, index 0, snapshot 0, SegmentDrivers all ones, SevenSegment 8'hFF, FrameStart 0, asynchronously.
REQ-025 Reset asserted mid-frame SHALL blank outputs immediately; after release, display SHALL restart at digit 0 with a fresh snapshot per REQ-017.

Structure
REQ-026 Package ss_pkg SHALL hold the 16-entry hex-to-segment constants and SEG_OFF = 8'hFF.
REQ-027 The hex decoder SHALL be a separate combinational sub-module hex7seg (4-bit in, 7-bit active-high segments out).

Verification (NUM_DIGITS=4, SLOT_W=4, BRIGHT_W=2)
REQ-028 Digits=16'h12AF, Brightness=3, Enable=1 -> drivers cycle 4'hE,D,B,7 every 16 clocks; SevenSegment decodes F,A,2,1 in turn; FrameStart pulses every 64 clocks.
REQ-029 Digits=16'h0050, LeadZeroSup=1 -> digit 3 and digit 2 blank (drivers high, 8'hFF); digits 1,0 show 5,0; with Digits=16'h0000, only digit 0 shows 0.
REQ-030 Brightness=0 -> each digit driver low 4 of 16 slot clocks; Brightness=2 -> 12 of 16.
REQ-031 Change Digits mid-frame from 16'h1111 to 16'h2222 -> remaining digits of that frame still show 1; 2 appears from the frame after the next FrameStart.
REQ-032 Reset pulsed low during digit 2 -> outputs 8'hFF/all-ones same cycle asynchronously; after release, digit 0 is driven first, with no glitch showing two drivers low.
